// File: rtl/cory_latency_mq.sv
// Latency-injecting in-order queue: D entries, each with its own countdown; build with CORY_LATENCY_MQ_STAT_EN for statistics.
// Latency: an item accepted with latency k is presented after edge t+k, so never sooner than the next cycle.
// Backpressure: o_a_r comes from registered occupancy only; the head waits on o_z_v until i_z_r takes it.
module cory_latency_mq #(
  parameter int N = 8,
  parameter int L = 8,
  parameter int D = 4,
  parameter int S = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 i_a_v,
  input  logic [N-1:0]         i_a_d,
  output logic                 o_a_r,
  output logic                 o_z_v,
  output logic [N-1:0]         o_z_d,
  input  logic                 i_z_r,
  input  logic [1:0]           i_mode,
  input  logic [L-1:0]         i_lat_min,
  input  logic [L-1:0]         i_lat_max,
  output logic [$clog2(D):0]   o_occ,
  output logic [31:0]          o_cnt_in,
  output logic [31:0]          o_cnt_out,
  output logic [$clog2(D):0]   o_peak_occ
);
  localparam int AW = $clog2(D);
  localparam logic [15:0] SEED = (16'(S) == 16'd0) ? 16'd1 : 16'(S);
  localparam logic [L-1:0] R_INIT = L'(S);
  localparam logic [AW:0] DEPTH = (AW+1)'(D);

  logic [D-1:0]  vld_q, vld_d;
  logic [N-1:0]  dat_q [D];
  logic [N-1:0]  dat_d [D];
  logic [L-1:0]  cnt_q [D];
  logic [L-1:0]  cnt_d [D];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   occ_q, occ_d;
  logic          en_q, en_d;
  logic [15:0]   lfsr_q, lfsr_d;
  logic [L-1:0]  r_q, r_d;

  logic          accept, deliver;
  logic [L:0]    span, rnd_off;
  logic [L-1:0]  lat;

  assign o_a_r   = en_q && (occ_q < DEPTH);
  assign o_z_v   = vld_q[rd_ptr_q] && (cnt_q[rd_ptr_q] == '0);
  assign o_z_d   = dat_q[rd_ptr_q];
  assign o_occ   = occ_q;
  assign accept  = i_a_v && o_a_r;
  assign deliver = o_z_v && i_z_r;

  // Random offset is drawn from the low L bits of the LFSR (L <= 16).
  always_comb begin
    span    = {1'b0, i_lat_max} - {1'b0, i_lat_min} + (L+1)'(1);
    rnd_off = '0;
    if (i_lat_max > i_lat_min) rnd_off = {1'b0, lfsr_q[L-1:0]} % span;
    case (i_mode)
      2'd0:    lat = '0;
      2'd1:    lat = i_lat_min;
      2'd2:    lat = L'({1'b0, i_lat_min} + rnd_off);
      default: lat = r_q;
    endcase
  end

  always_comb begin
    vld_d    = vld_q;
    dat_d    = dat_q;
    cnt_d    = cnt_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    lfsr_d   = lfsr_q;
    r_d      = r_q;
    en_d     = 1'b1;
    for (int i = 0; i < D; i++) begin
      if (vld_q[i] && cnt_q[i] != '0) cnt_d[i] = cnt_q[i] - 1'b1;
    end
    if (deliver) begin
      vld_d[rd_ptr_q] = 1'b0;
      rd_ptr_d        = rd_ptr_q + 1'b1;
      r_d             = L'(32'(r_q) * 32'd21 + 32'd1);
    end
    // Accept is blocked when full, so the write slot never aliases the head.
    if (accept) begin
      vld_d[wr_ptr_q] = 1'b1;
      dat_d[wr_ptr_q] = i_a_d;
      cnt_d[wr_ptr_q] = lat;
      wr_ptr_d        = wr_ptr_q + 1'b1;
      lfsr_d          = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
    end
    occ_d = occ_q + (AW+1)'(accept) - (AW+1)'(deliver);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
      en_q     <= 1'b0;
      lfsr_q   <= SEED;
      r_q      <= R_INIT;
      for (int i = 0; i < D; i++) begin
        dat_q[i] <= '0;
        cnt_q[i] <= '0;
      end
    end else begin
      vld_q    <= vld_d;
      dat_q    <= dat_d;
      cnt_q    <= cnt_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
      en_q     <= en_d;
      lfsr_q   <= lfsr_d;
      r_q      <= r_d;
    end
  end

`ifdef CORY_LATENCY_MQ_STAT_EN
  logic [31:0] cnt_in_q, cnt_in_d, cnt_out_q, cnt_out_d;
  logic [AW:0] peak_q, peak_d;

  // Peak follows next occupancy so it never lags o_occ.
  always_comb begin
    cnt_in_d  = cnt_in_q + 32'(accept);
    cnt_out_d = cnt_out_q + 32'(deliver);
    peak_d    = (occ_d > peak_q) ? occ_d : peak_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_in_q  <= '0;
      cnt_out_q <= '0;
      peak_q    <= '0;
    end else begin
      cnt_in_q  <= cnt_in_d;
      cnt_out_q <= cnt_out_d;
      peak_q    <= peak_d;
    end
  end

  assign o_cnt_in   = cnt_in_q;
  assign o_cnt_out  = cnt_out_q;
  assign o_peak_occ = peak_q;
`else
  assign o_cnt_in   = '0;
  assign o_cnt_out  = '0;
  assign o_peak_occ = '0;
`endif
endmodule

// File: tb/tb_cory_latency_mq.sv
// Randomized bench for cory_latency_mq: driver issues traffic, a negedge scoreboard predicts every output.
module tb_cory_latency_mq;
  logic       clk = 1'b0;
  logic       reset;
  logic       i_a_v, o_a_r, o_z_v, i_z_r;
  logic [7:0] i_a_d, o_z_d, i_lat_min, i_lat_max;
  logic [1:0] i_mode;
  logic [2:0] o_occ, o_peak_occ;
  logic [31:0] o_cnt_in, o_cnt_out;

  cory_latency_mq #(.N(8), .L(8), .D(4), .S(1)) dut (
    .clk(clk), .reset(reset),
    .i_a_v(i_a_v), .i_a_d(i_a_d), .o_a_r(o_a_r),
    .o_z_v(o_z_v), .o_z_d(o_z_d), .i_z_r(i_z_r),
    .i_mode(i_mode), .i_lat_min(i_lat_min), .i_lat_max(i_lat_max),
    .o_occ(o_occ), .o_cnt_in(o_cnt_in), .o_cnt_out(o_cnt_out), .o_peak_occ(o_peak_occ)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] d;
    int         rdy;   // first edge count at which the item is presented
    int         acc;   // edge count at which it was accepted
  } ent_t;

  ent_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  logic [15:0] lfsr_m;
  int          r_m;
  bit          en_m;
  bit          head_seen;
  logic [31:0] cin_m, cout_m;
  int          peak_m;
  bit          m2_phase = 0;
  bit          seen2 = 0, seen9 = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [15:0] lfsr_step(input logic [15:0] x);
    return (x >> 1) ^ (x[0] ? 16'hB400 : 16'h0000);
  endfunction

  // Scoreboard / monitor: inputs are stable here, so this sees exactly what the next edge will sample.
  always @(negedge clk) begin
    int  sz, lat, meas;
    bit  exp_v, exp_ar, acc, dlv;
    sz = sb.size();
    if (reset) begin
      chk("rst_z_v", 32'(o_z_v), 32'd0);
      chk("rst_occ", 32'(o_occ), 32'd0);
      chk("rst_a_r", 32'(o_a_r), 32'd0);
      sb.delete();
      lfsr_m = 16'd1; r_m = 1; en_m = 0; head_seen = 0;
      cin_m = 0; cout_m = 0; peak_m = 0;
    end else begin
      exp_v  = (sz > 0) && (cyc >= sb[0].rdy);
      exp_ar = en_m && (sz < 4);
      chk("z_v", 32'(o_z_v), 32'(exp_v));
      chk("a_r", 32'(o_a_r), 32'(exp_ar));
      chk("occ", 32'(o_occ), 32'(sz));
      if (exp_v) chk("z_d", 32'(o_z_d), 32'(sb[0].d));
      if (exp_v && o_z_v && !head_seen) begin
        head_seen = 1;
        meas = cyc - sb[0].acc;
        if (m2_phase) begin
          chk("m2_range", 32'(meas >= 2 && meas <= 9), 32'd1);
          if (meas == 2) seen2 = 1;
          if (meas == 9) seen9 = 1;
        end
      end
      if (sz > peak_m) peak_m = sz;
`ifdef CORY_LATENCY_MQ_STAT_EN
      chk("cnt_in", o_cnt_in, cin_m);
      chk("cnt_out", o_cnt_out, cout_m);
      chk("peak_occ", 32'(o_peak_occ), 32'(peak_m));
`else
      chk("cnt_in_tied", o_cnt_in, 32'd0);
      chk("cnt_out_tied", o_cnt_out, 32'd0);
      chk("peak_tied", 32'(o_peak_occ), 32'd0);
`endif
      dlv = exp_v && i_z_r;
      acc = exp_ar && i_a_v;
      case (i_mode)
        2'd0: lat = 0;
        2'd1: lat = int'(i_lat_min);
        2'd2: lat = (i_lat_max > i_lat_min)
                    ? int'(i_lat_min) + (int'(lfsr_m & 16'h00FF) % (int'(i_lat_max) - int'(i_lat_min) + 1))
                    : int'(i_lat_min);
        default: lat = r_m;
      endcase
      if (dlv) begin
        void'(sb.pop_front());
        head_seen = 0;
        cout_m++;
        r_m = (r_m * 21 + 1) % 256;
      end
      if (acc) begin
        sb.push_back('{d: i_a_d, rdy: cyc + 1 + lat, acc: cyc + 1});
        lfsr_m = lfsr_step(lfsr_m);
        cin_m++;
      end
      en_m = 1;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1; i_a_v = 0; i_a_d = 0; i_z_r = 0;
    i_mode = 0; i_lat_min = 0; i_lat_max = 0;
    repeat (3) step();
    reset = 0;

    // Zero latency, back-to-back, sink always ready.
    i_mode = 0; i_z_r = 1;
    for (int i = 0; i < 10; i++) begin
      i_a_v = 1; i_a_d = 8'($urandom); step();
    end
    i_a_v = 0; repeat (4) step();

    // Single item with fixed latency 5.
    i_mode = 1; i_lat_min = 5;
    i_a_v = 1; i_a_d = 8'($urandom); step();
    i_a_v = 0; repeat (10) step();

    // Fill with sink stalled, then release.
    i_mode = 0; i_z_r = 0; i_a_v = 1;
    for (int i = 0; i < 8; i++) begin i_a_d = 8'($urandom); step(); end
    i_z_r = 1;
    for (int i = 0; i < 2; i++) begin i_a_d = 8'($urandom); step(); end
    i_a_v = 0; repeat (8) step();

    // Random latency between 2 and 9.
    i_mode = 2; i_lat_min = 2; i_lat_max = 9; m2_phase = 1;
    for (int i = 0; i < 3000; i++) begin
      i_a_v = ($urandom_range(9, 0) < 7); i_a_d = 8'($urandom); step();
    end
    i_a_v = 0; repeat (15) step();
    m2_phase = 0;

    // Everything random, including mode/bound changes with items in flight.
    for (int i = 0; i < 3000; i++) begin
      if (i % 40 == 0) begin
        i_mode = 2'($urandom); i_lat_min = 8'($urandom_range(12, 0));
        i_lat_max = 8'($urandom_range(14, 0));
      end
      i_a_v = ($urandom_range(9, 0) < 6); i_z_r = ($urandom_range(9, 0) < 6);
      i_a_d = 8'($urandom); step();
    end
    i_a_v = 0; i_z_r = 1; repeat (300) step();

    // Reset with three slow items in flight; none may reappear.
    i_mode = 1; i_lat_min = 20;
    i_a_v = 1;
    for (int i = 0; i < 3; i++) begin i_a_d = 8'($urandom); step(); end
    i_a_v = 0; repeat (2) step();
    reset = 1; repeat (2) step();
    reset = 0; repeat (30) step();

    // Degenerate random bounds fall back to the minimum.
    i_mode = 2; i_lat_min = 6; i_lat_max = 3;
    for (int i = 0; i < 40; i++) begin
      i_a_v = 1; i_a_d = 8'($urandom); i_z_r = ($urandom_range(1, 0) == 1); step();
    end
    i_a_v = 0; i_z_r = 1; repeat (20) step();

    chk("m2_saw_lat2", 32'(seen2), 32'd1);
    chk("m2_saw_lat9", 32'(seen9), 32'd1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/cory_latency_mq.md
CORY_LATENCY_MQ -- requirements
Module: cory_latency_mq

Interface
REQ-001 SHALL have parameter N, default 8, data width in bits.
REQ-002 SHALL have parameter L, default 8, latency width in bits; max per-item latency 2^L-1.
REQ-003 SHALL have parameter D, default 4, in-flight entry count; power of two, D>=2.
REQ-004 SHALL have parameter S, default 1, seed for the LFSR and for mode-3 latency.
REQ-005 SHALL have port clk, input, 1: sole clock, rising edge.
REQ-006 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-007 SHALL have ports i_a_v input 1, i_a_d input N, o_a_r output 1: upstream valid/data/ready.
REQ-008 SHALL have ports o_z_v output 1, o_z_d output N, i_z_r input 1: downstream valid/data/ready.
REQ-009 SHALL have port i_mode, input, 2: latency mode select.
REQ-010 SHALL have ports i_lat_min and i_lat_max, input, L each: latency bounds.
REQ-011 SHALL have port o_occ, output, $clog2(D)+1: current entry count.
REQ-012 SHALL have ports o_cnt_in and o_cnt_out, output, 32 each, and o_peak_occ, output, $clog2(D)+1: statistics.

Function
REQ-013 SHALL transfer on a side when valid and ready are both high at a rising clk edge.
REQ-014 SHALL drive o_a_r = (o_occ < D), with no combinational dependence on i_z_r or i_a_v.
REQ-015 SHALL store each accepted item in a FIFO entry with a per-entry L-bit countdown loaded with the item's latency lat.
REQ-016 SHALL decrement every occupied entry's nonzero countdown by 1 each cycle, saturating at 0.
REQ-017 SHALL assert o_z_v when the FIFO is non-empty and the head countdown is 0; o_z_d = head data.
REQ-018 SHALL deliver in acceptance order; an item behind a slower head waits, effective latency = max(own, head remaining).
REQ-019 SHALL make an item accepted at edge t with lat=k visible on o_z_v no earlier than the cycle after edge t+k (minimum 1 cycle).
REQ-020 SHALL hold o_z_v and o_z_d stable while o_z_v=1 and i_z_r=0.
REQ-021 SHALL select lat at acceptance: mode 0 -> 0; mode 1 -> i_lat_min; mode 2 -> random; mode 3 -> recurrence.
REQ-022 SHALL compute mode-2 lat = i_lat_min + (r mod (i_lat_max-i_lat_min+1)), r = LFSR[L-1:0]; lat = i_lat_min when i_lat_max <= i_lat_min.
REQ-023 SHALL use a 16-bit Galois LFSR, taps 0xB400, seeded with S (0 replaced by 1), stepping once per accepted item in any mode.
REQ-024 SHALL compute mode-3 lat from register R (reset S[L-1:0]), updating R <= R*21+1 mod 2^L on each downstream transfer.
REQ-025 SHALL apply i_mode, i_lat_min and i_lat_max changes only to items accepted afterwards.
REQ-026 SHALL keep o_occ unchanged on simultaneous accept and deliver; when full, no accept that cycle even if the head is delivered.
REQ-027 SHALL wrap FIFO read/write pointers modulo D without losing or duplicating items.

Reset
REQ-028 SHALL, on reset high, asynchronously clear all entries and set o_occ=0, o_z_v=0, o_a_r=0.
REQ-029 SHALL, on reset, set the LFSR to its seed, R=S[L-1:0], and clear all statistics.
REQ-030 SHALL, after reset deasserts, drive o_a_r=1 from the first following clk edge; a reset mid-operation discards all in-flight items.

Configuration
REQ-031 SHALL, with macro CORY_LATENCY_MQ_STAT_EN defined, count accepted items in o_cnt_in and delivered items in o_cnt_out (32-bit, wrapping), and track the maximum o_occ in o_peak_occ.
REQ-032 SHALL, without CORY_LATENCY_MQ_STAT_EN, tie o_cnt_in, o_cnt_out and o_peak_occ to 0, with all other behaviour identical.

Verification
REQ-033 SHALL pass: mode 0, i_z_r=1, 10 back-to-back items -> each output 1 cycle after accept, 100% throughput, order preserved.
REQ-034 SHALL pass: mode 1, i_lat_min=5, single item at edge t -> o_z_v first high after edge t+5, o_occ returns to 0 after delivery.
REQ-035 SHALL pass: D=4, i_z_r=0, 6 items offered -> 4 accepted, o_a_r=0, o_occ=4; release i_z_r -> all 6 delivered in order.
REQ-036 SHALL pass: mode 2, min=2, max=9, 1000 items -> every measured latency in [2,9] (order-stall aside), values 2 and 9 both observed.
REQ-037 SHALL pass: reset pulsed with 3 items in flight -> o_z_v=0, o_occ=0 immediately, no item from before reset ever appears.
REQ-038 SHALL pass: STAT_EN defined, 50 accepted, 47 delivered -> o_cnt_in=50, o_cnt_out=47, o_peak_occ equals observed max o_occ.
